// File: rtl/alu_4b_pkg.sv
// Shared definitions for the 4-bit ALU divide path: operand width, FSM encoding
// and the quotient value reported on divide-by-zero.
package alu_4b_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] DBZ_QUOT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/div_4b_issue_if.sv
// Request/result handshake bundle between the issue stage and its neighbours.
// The slave modport is the divider stage; the master modport is the requester/consumer side.
interface div_4b_issue_if;
  import alu_4b_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_a;
  logic [OP_W-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] out_quot;
  logic [OP_W-1:0] out_rem;
  logic            out_dbz;
  logic            busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_quot, out_rem, out_dbz, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_quot, out_rem, out_dbz, busy
  );

endinterface

// File: rtl/_4b_div.sv
// Combinational unsigned 4-bit restoring divider.
// With b=0 it degenerates to quot=all-ones, rem=a; the issue stage overrides that case anyway.
module _4b_div
  import alu_4b_pkg::*;
(
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  output logic [OP_W-1:0] quot_o,
  output logic [OP_W-1:0] rem_o
);

  logic [OP_W:0] part_rem;

  always_comb begin
    part_rem = '0;
    quot_o   = '0;
    for (int i = OP_W - 1; i >= 0; i--) begin
      part_rem = {part_rem[OP_W-1:0], a_i[i]};
      if (part_rem >= {1'b0, b_i}) begin
        part_rem  = part_rem - {1'b0, b_i};
        quot_o[i] = 1'b1;
      end
    end
    rem_o = part_rem[OP_W-1:0];
  end

endmodule

// File: rtl/div_4b_issue.sv
// Issue/capture stage around _4b_div: accepts an operand pair, holds it for
// SETTLE_CYCLES edges, captures quotient/remainder/dbz and presents them downstream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a request, in_ready high
// ST_SETTLE | operands held on the divider, cnt_q counting down to capture
// ST_DONE   | result registers valid, waiting for out_ready
module div_4b_issue
  import alu_4b_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // legal range 1..7
) (
  input  logic          clk,
  input  logic          rst_n,
  div_4b_issue_if.slave bus
);

  localparam logic [2:0] CNT_LOAD = 3'(SETTLE_CYCLES - 1);

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic [OP_W-1:0] op_a_q;
  logic [OP_W-1:0] op_b_q;
  logic [OP_W-1:0] quot_q;
  logic [OP_W-1:0] rem_q;
  logic            dbz_q;

  logic [OP_W-1:0] div_quot;
  logic [OP_W-1:0] div_rem;
  logic            accept;

  _4b_div u_div (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .quot_o (div_quot),
    .rem_o  (div_rem)
  );

  // rst_n is folded in so the requester sees in_ready low for the whole reset.
  assign bus.in_ready = ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready)) & rst_n;
  assign accept       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      // Reachable from IDLE, or from DONE when the old result is consumed at the same edge.
      op_a_q  <= bus.in_a;
      op_b_q  <= bus.in_b;
      cnt_q   <= CNT_LOAD;
      state_q <= ST_SETTLE;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SETTLE: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            state_q <= ST_DONE;
            if (op_b_q == '0) begin
              quot_q <= DBZ_QUOT;
              rem_q  <= op_a_q;
              dbz_q  <= 1'b1;
            end else begin
              quot_q <= div_quot;
              rem_q  <= div_rem;
              dbz_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_SETTLE) | (state_q == ST_DONE);
  assign bus.out_quot  = quot_q;
  assign bus.out_rem   = rem_q;
  assign bus.out_dbz   = dbz_q;

endmodule

// File: tb/tb_div_4b_issue.sv
// Bench for div_4b_issue: scoreboarded random/directed traffic on a SETTLE_CYCLES=1
// instance, plus directed latency/reset-abort checks on a SETTLE_CYCLES=4 instance.
module tb_div_4b_issue;

  localparam int SC_A = 1;
  localparam int SC_B = 4;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
    int         acc_cyc;
  } exp_t;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;
  int   cyc;
  int   tests;
  int   fails;
  int   n_acc;
  int   n_res;
  int   rdy_mode;
  exp_t sb[$];

  div_4b_issue_if bus_a ();
  div_4b_issue_if bus_b ();

  div_4b_issue #(.SETTLE_CYCLES(SC_A)) u_dut_a (.clk(clk), .rst_n(rst_a_n), .bus(bus_a.slave));
  div_4b_issue #(.SETTLE_CYCLES(SC_B)) u_dut_b (.clk(clk), .rst_n(rst_b_n), .bus(bus_b.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: plain unsigned division, dbz rule for b=0.
  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input int c);
    exp_t e;
    int   ai;
    int   bi;
    ai        = int'(a);
    bi        = int'(b);
    e.acc_cyc = c;
    if (bi == 0) begin
      e.q   = 4'hF;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = 4'(ai / bi);
      e.r   = 4'(ai - bi * (ai / bi));
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic send(input logic [3:0] a, input logic [3:0] b, output int acc);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    acc = -1;
    @(negedge clk);
    bus_a.in_a     = a;
    bus_a.in_b     = b;
    bus_a.in_valid = 1'b1;
    while (!got && n < 100) begin
      #4;
      got = bus_a.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!got) @(negedge clk);
    end
    bus_a.in_valid = 1'b0;
    if (!got) begin
      chk("accept_timeout", 0, 1);
    end else begin
      acc = cyc;
      sb.push_back(model(a, b, cyc));
      n_acc++;
    end
  endtask

  // Downstream ready pattern: 0 = always ready, 1 = random stalls, 2 = stalled.
  initial begin
    bus_a.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus_a.out_ready = 1'b1;
        1:       bus_a.out_ready = ($urandom_range(0, 3) != 0);
        default: bus_a.out_ready = 1'b0;
      endcase
    end
  end

  // Result monitor: just before each edge compare presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_a_n && bus_a.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_result", sb.size(), 1);
        end else begin
          chk("quot", bus_a.out_quot, sb[0].q);
          chk("rem", bus_a.out_rem, sb[0].r);
          chk("dbz", bus_a.out_dbz, sb[0].dbz);
          chk("in_ready_in_done", bus_a.in_ready, bus_a.out_ready);
          if (bus_a.out_ready) begin
            void'(sb.pop_front());
            n_res++;
          end
        end
      end
    end
  end

  // Latency monitor: out_valid must rise exactly SC_A edges after the accept edge.
  initial begin
    bit pv;
    pv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_a.out_valid && !pv) begin
        if (sb.size() == 0) chk("latency_no_request", sb.size(), 1);
        else chk("latency", cyc - sb[0].acc_cyc, SC_A);
      end
      pv = bus_a.out_valid;
    end
  end

  initial begin
    int k1;
    int k2;
    int n;
    tests    = 0;
    fails    = 0;
    n_acc    = 0;
    n_res    = 0;
    rdy_mode = 0;
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_a      = '0;
    bus_a.in_b      = '0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_a      = '0;
    bus_b.in_b      = '0;
    bus_b.out_ready = 1'b1;

    #2;
    chk("rst_in_ready", bus_a.in_ready, 0);
    chk("rst_out_valid", bus_a.out_valid, 0);
    chk("rst_outputs", {bus_a.out_quot, bus_a.out_rem, bus_a.out_dbz, bus_a.busy}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    #1;
    chk("in_ready_after_rst", bus_a.in_ready, 1);

    // Basic op, then back to idle.
    send(4'd4, 4'd2, k1);
    repeat (3) @(negedge clk);
    chk("idle_busy", bus_a.busy, 0);
    chk("idle_in_ready", bus_a.in_ready, 1);

    // Stalled downstream: result must hold and in_ready stay low.
    rdy_mode = 2;
    @(negedge clk);
    send(4'd13, 4'd4, k1);
    n = 0;
    while (!bus_a.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid", bus_a.out_valid, 1);
    repeat (5) @(negedge clk);
    chk("stall_in_ready", bus_a.in_ready, 0);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("stall_consumed", bus_a.out_valid, 0);

    send(4'd9, 4'd0, k1);

    // Back-to-back: second request accepted on the consume edge.
    send(4'd8, 4'd3, k1);
    send(4'd15, 4'd5, k2);
    chk("b2b_gap", k2 - k1, SC_A + 1);

    // Full sweep in shuffled order with random stalls and request gaps.
    rdy_mode = 1;
    begin
      int off;
      off = int'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) begin
        logic [7:0] ab;
        ab = 8'((i * 37 + off) % 256);
        send(ab[7:4], ab[3:0], k1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    for (int i = 0; i < 40; i++) send(4'($urandom), 4'($urandom), k1);

    rdy_mode = 0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    chk("result_count", n_res, n_acc);

    // Instance B: latency with a longer settle window.
    @(negedge clk);
    bus_b.in_a     = 4'd7;
    bus_b.in_b     = 4'd2;
    bus_b.in_valid = 1'b1;
    #4;
    chk("b_in_ready", bus_b.in_ready, 1);
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    bus_b.in_a     = 4'hF;
    bus_b.in_b     = 4'h0;
    for (int i = 1; i < SC_B; i++) begin
      @(posedge clk);
      #1;
      chk("b_settle_valid", bus_b.out_valid, 0);
      chk("b_settle_busy", bus_b.busy, 1);
    end
    @(posedge clk);
    #1;
    chk("b_valid", bus_b.out_valid, 1);
    chk("b_quot", bus_b.out_quot, 3);
    chk("b_rem", bus_b.out_rem, 1);
    chk("b_dbz", bus_b.out_dbz, 0);
    @(posedge clk);
    #1;
    chk("b_consumed", bus_b.out_valid, 0);

    // Instance B: reset two edges into SETTLE drops the operation.
    @(negedge clk);
    bus_b.in_a     = 4'd11;
    bus_b.in_b     = 4'd3;
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b_n = 1'b0;
    #1;
    chk("b_rst_valid", bus_b.out_valid, 0);
    chk("b_rst_quot", bus_b.out_quot, 0);
    chk("b_rst_rem", bus_b.out_rem, 0);
    chk("b_rst_dbz", bus_b.out_dbz, 0);
    chk("b_rst_busy", bus_b.busy, 0);
    chk("b_rst_in_ready", bus_b.in_ready, 0);
    repeat (2) @(negedge clk);
    rst_b_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("b_no_result", bus_b.out_valid, 0);
    end
    chk("b_idle_after_rst", bus_b.in_ready, 1);

    @(negedge clk);
    bus_b.in_a     = 4'd6;
    bus_b.in_b     = 4'd3;
    bus_b.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    repeat (SC_B) @(posedge clk);
    #1;
    chk("b_next_valid", bus_b.out_valid, 1);
    chk("b_next_quot", bus_b.out_quot, 2);
    chk("b_next_rem", bus_b.out_rem, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_4b_issue.md
# div_4b_issue

Sequential issue/capture stage wrapped around the existing combinational 4-bit divider `_4b_div`. Accepts one unsigned dividend/divisor pair over a valid/ready handshake and holds the operands stable for a programmable settle window. Captures quotient and remainder into registers, flags divide-by-zero, and presents the result over a second valid/ready handshake to the ALU result mux downstream.

## Interface
- SETTLE_CYCLES, 1, rising edges the operands are held on `_4b_div` before capture; legal range 1..7
- clk  input  1  single clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request carries a valid operand pair
- in_ready  output  1  stage can accept a request this cycle
- in_a  input  4  dividend, unsigned
- in_b  input  4  divisor, unsigned
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  downstream consumes the result this cycle
- out_quot  output  4  registered quotient
- out_rem  output  4  registered remainder
- out_dbz  output  1  registered divide-by-zero flag
- busy  output  1  high in SETTLE or DONE

## Operation
- One clock, one reset. Reset is asynchronous and active-low (`rst_n`). All state clears immediately on `rst_n` low.
- States:
  - IDLE: in_ready=1.
  - SETTLE: down-counter `cnt`, 3 bits.
  - DONE: out_valid=1.
- Accept = in_valid & in_ready at a rising edge.
  - Registers in_a/in_b into op_a/op_b.
  - Loads cnt = SETTLE_CYCLES-1.
  - Moves to SETTLE.
- SETTLE, each edge:
  - cnt≠0: decrement cnt.
  - cnt=0: capture results, go to DONE.
- Capture, b≠0: out_quot/out_rem = `_4b_div` outputs for op_a/op_b, out_dbz=0.
- Capture, b=0: out_quot=4'hF, out_rem=op_a, out_dbz=1. Divider outputs are ignored.
- DONE, out_ready=1:
  - Result is consumed at the edge.
  - If in_valid is also high, the new pair is accepted at the same edge and the state goes straight to SETTLE.
  - Otherwise the state goes to IDLE.
- DONE, out_ready=0: hold. out_quot/out_rem/out_dbz must not change while out_valid & !out_ready.
- in_ready = (IDLE | (DONE & out_ready)) & rst_n. It is a combinational function of state and out_ready. There is no other combinational input-to-output path.
- in_a/in_b are ignored when no accept occurs. Changes to in_a/in_b during SETTLE have no effect.
- All arithmetic is unsigned 4-bit.
  - Quotient = floor(a/b), remainder = a − b·quot.
  - Both always fit in 4 bits.

## Timing
- Reset values: in_ready=0 while rst_n low. out_valid=0, out_quot=0, out_rem=0, out_dbz=0, busy=0, state=IDLE.
- in_ready rises combinationally once rst_n deasserts.
- Latency: accept at edge k → out_valid high after edge k+SETTLE_CYCLES.
- Throughput with out_ready held high: one result per SETTLE_CYCLES+1 edges.
- Reset asserted mid-operation (SETTLE or DONE): the operation is dropped and no result is presented. After deassertion the block is in IDLE.
- Simultaneous consume and accept in DONE:
  - out_valid goes low for the SETTLE cycles.
  - The old result registers keep their values until the next capture.
- in_valid asserted during reset or during SETTLE: not accepted. The requester must hold the request until in_ready.

## Structure
- Shared package `alu_4b_pkg`:
  - state encoding (IDLE=2'd0, SETTLE=2'd1, DONE=2'd2)
  - operand width 4
  - DBZ_QUOT=4'hF
- Instantiate `_4b_div` unchanged as the only sub-module, driven from op_a/op_b.
- Everything else (FSM, counter, result registers) lives in `div_4b_issue`.

## Test plan
- Reset then a=4, b=2, SETTLE_CYCLES=1, out_ready=1 → out_valid exactly 1 edge after accept, quot=2, rem=0, dbz=0; back to IDLE.
- a=13, b=4 with out_ready=0 for 5 cycles → quot=3, rem=1 held stable with out_valid=1; in_ready=0 throughout; consumed when out_ready rises.
- a=9, b=0 → quot=4'hF, rem=9, dbz=1.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (a=15, b=5) → same-edge accept; next result quot=3, rem=0; no IDLE cycle between.
- SETTLE_CYCLES=4, rst_n pulsed low 2 edges after accept → out_valid=0 and all outputs 0 immediately; no result ever appears; the next request completes normally.
- Exhaustive sweep of all 256 a/b pairs with random out_ready stalls → every result matches the a/b reference model (dbz rule for b=0); each accepted request produces exactly one result.
